// File: rtl/fp_acc_seq.sv
// fp_acc_seq: sequencer around an external combinational FP32 adder.
//
// Accepts `count` single-precision operands over a valid/ready handshake. The
// adder is fed from registers only ({acc, op_reg}) and its result is captured
// back into the accumulator. The final sum is then offered on a valid/ready
// output.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   start, count        begin a run of `count` operands (sampled in IDLE only)
//   in_valid/in_ready   operand handshake, in_data is the FP32 operand
//   add_a, add_b        adder inputs (accumulator, operand register)
//   add_res             adder result
//   sum_valid/sum_ready result handshake, sum_data is the final sum
//   busy                high whenever not IDLE
//
// Optional build macro FP_ZERO_BYPASS_EN: in NEXT, an accepted +/-0 operand
// leaves acc unchanged and skips the ADD state.

module fp_acc_seq #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned ADD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_res,
    output logic             sum_valid,
    output logic [31:0]      sum_data,
    input  logic             sum_ready,
    output logic             busy
);

    localparam int unsigned WAIT_W = 4;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(ADD_LAT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFirst,
        StNext,
        StAdd,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        acc_q, acc_d;
    logic [31:0]        op_q, op_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;

    logic [CNT_W-1:0]   rem_dec;
    logic               zero_bypass;

    // Saturating decrement: the down-counter never wraps.
    assign rem_dec = (rem_q != '0) ? rem_q - CNT_W'(1) : rem_q;

`ifdef FP_ZERO_BYPASS_EN
    assign zero_bypass = (in_data[30:0] == 31'd0);
`else
    assign zero_bypass = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            op_q    <= '0;
            rem_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        op_d      = op_q;
        rem_d     = rem_q;
        wait_d    = wait_q;
        in_ready  = 1'b0;
        sum_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (count == '0) begin
                        acc_d   = '0;
                        state_d = StDone;
                    end else begin
                        rem_d   = count;
                        state_d = StFirst;
                    end
                end
            end

            StFirst: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // First operand seeds the accumulator directly, no add.
                    acc_d   = in_data;
                    rem_d   = rem_dec;
                    state_d = (rem_dec == '0) ? StDone : StNext;
                end
            end

            StNext: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (zero_bypass) begin
                        rem_d   = rem_dec;
                        state_d = (rem_dec == '0) ? StDone : StNext;
                    end else begin
                        op_d    = in_data;
                        wait_d  = WAIT_INIT;
                        state_d = StAdd;
                    end
                end
            end

            StAdd: begin
                // Adder inputs are held for ADD_LAT cycles; sample on the last.
                if (wait_q != '0) begin
                    wait_d = wait_q - WAIT_W'(1);
                end else begin
                    acc_d   = add_res;
                    rem_d   = rem_dec;
                    state_d = (rem_dec == '0) ? StDone : StNext;
                end
            end

            StDone: begin
                sum_valid = 1'b1;
                if (sum_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign add_a    = acc_q;
    assign add_b    = op_q;
    assign sum_data = acc_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_fp_acc_seq.sv
// Bench for fp_acc_seq: two instances (ADD_LAT=1 and ADD_LAT=3) each with a
// behavioural adder that returns garbage until its inputs have been stable for
// ADD_LAT cycles, so early sampling or unstable inputs corrupt the sum.

module tb_fp_acc_seq;

    logic        clk = 1'b0;
    logic        rst       [2];
    logic        start     [2];
    logic [7:0]  cnt       [2];
    logic        in_valid  [2];
    logic [31:0] in_data   [2];
    logic        in_ready  [2];
    logic [31:0] add_a     [2];
    logic [31:0] add_b     [2];
    logic [31:0] add_res   [2];
    logic        sum_valid [2];
    logic [31:0] sum_data  [2];
    logic        sum_ready [2];
    logic        busy      [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Positive normal / zero FP32 add, truncating; exact for the vectors used.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [7:0]  ea, eb, et;
        logic [24:0] ma, mb, mt, s;
        if (a[30:0] == 31'd0) return b;
        if (b[30:0] == 31'd0) return a;
        ea = a[30:23]; eb = b[30:23];
        ma = {2'b01, a[22:0]}; mb = {2'b01, b[22:0]};
        if (eb > ea) begin
            et = ea; ea = eb; eb = et;
            mt = ma; ma = mb; mb = mt;
        end
        mb = mb >> (ea - eb);
        s = ma + mb;
        if (s[24]) begin
            s  = s >> 1;
            ea = ea + 8'd1;
        end
        return {1'b0, ea, s[22:0]};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int unsigned LAT = (g == 0) ? 1 : 3;
        logic [31:0] pa = '0;
        logic [31:0] pb = '0;
        int hc = 0;
        int stab;

        always_comb stab = (add_a[g] == pa && add_b[g] == pb) ? hc + 1 : 1;

        always @(posedge clk) begin
            pa <= add_a[g];
            pb <= add_b[g];
            hc <= stab;
        end

        assign add_res[g] = (stab >= int'(LAT)) ? fadd(add_a[g], add_b[g]) : 32'hDEADBEEF;

        fp_acc_seq #(
            .CNT_W  (8),
            .ADD_LAT(LAT)
        ) u_dut (
            .clk      (clk),
            .rst      (rst[g]),
            .start    (start[g]),
            .count    (cnt[g]),
            .in_valid (in_valid[g]),
            .in_data  (in_data[g]),
            .in_ready (in_ready[g]),
            .add_a    (add_a[g]),
            .add_b    (add_b[g]),
            .add_res  (add_res[g]),
            .sum_valid(sum_valid[g]),
            .sum_data (sum_data[g]),
            .sum_ready(sum_ready[g]),
            .busy     (busy[g])
        );
    end

    typedef logic [7:0][31:0] ops_t;

    typedef struct {
        int          inst;
        int          n;
        ops_t        ops;
        bit          toggle;
        int          stall;
        bit          poke;
        logic [31:0] exp_sum;
        int          exp_lat;   // -1: not checked
        int          exp_hs;
        int          exp_add;
        bit          exp_rdy;
    } vec_t;

    function automatic ops_t mk(input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] a2, input logic [31:0] a3);
        ops_t r;
        r = '0;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One run: start, stream operands, collect the sum.
    task automatic run(input int idx, input int n, input ops_t ops, input bit toggle,
                       input int stall, input bit poke,
                       output logic [31:0] res, output int lat, output int hs_cnt,
                       output int add_cyc, output bit stable_ok, output bit rdy_seen,
                       output bit done);
        int  p, stall_left;
        bit  held, hs_in, hs_out;
        p = 0; lat = -1; stall_left = stall; res = '0; hs_cnt = 0; add_cyc = 0;
        stable_ok = 1'b1; rdy_seen = 1'b0; held = 1'b0; done = 1'b0;
        start[idx] = 1'b1;
        cnt[idx]   = 8'(n);
        for (int c = 0; c < 300 && !done; c++) begin
            in_valid[idx]  = (p < n) && (!toggle || (c % 2 == 0));
            in_data[idx]   = ops[p % 8];
            sum_ready[idx] = (stall_left == 0);
            hs_in  = in_valid[idx] && in_ready[idx];
            hs_out = sum_valid[idx] && sum_ready[idx];
            if (in_ready[idx]) rdy_seen = 1'b1;
            if (busy[idx] && !in_ready[idx] && !sum_valid[idx]) add_cyc++;
            if (sum_valid[idx]) begin
                if (lat < 0) lat = c;
                if (held && sum_data[idx] !== res) stable_ok = 1'b0;
                res  = sum_data[idx];
                held = 1'b1;
                if (!sum_ready[idx]) stall_left--;
            end
            tick();
            if (hs_in) begin
                p++;
                hs_cnt++;
            end
            if (hs_out) done = 1'b1;
            start[idx] = poke && held && !done;
        end
        start[idx]     = 1'b0;
        in_valid[idx]  = 1'b0;
        sum_ready[idx] = 1'b0;
    endtask

    vec_t        vecs [5];
    logic [31:0] res;
    int          lat, hs_cnt, add_cyc;
    bit          stable_ok, rdy_seen, done;
    bit          found;

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; start[i] = 1'b0; cnt[i] = '0; in_valid[i] = 1'b0;
            in_data[i] = '0; sum_ready[i] = 1'b0;
        end

        vecs[0] = '{inst: 0, n: 3, ops: mk(32'h3F800000, 32'h40000000, 32'h40400000, 32'h0),
                    toggle: 0, stall: 0, poke: 0, exp_sum: 32'h40C00000, exp_lat: 6,
                    exp_hs: 3, exp_add: 2, exp_rdy: 1};
        vecs[1] = '{inst: 0, n: 0, ops: mk(32'h3F800000, 32'h0, 32'h0, 32'h0),
                    toggle: 0, stall: 0, poke: 0, exp_sum: 32'h00000000, exp_lat: 1,
                    exp_hs: 0, exp_add: 0, exp_rdy: 0};
        vecs[2] = '{inst: 0, n: 2, ops: mk(32'h40400000, 32'h40400000, 32'h0, 32'h0),
                    toggle: 0, stall: 5, poke: 1, exp_sum: 32'h40C00000, exp_lat: 4,
                    exp_hs: 2, exp_add: 1, exp_rdy: 1};
        vecs[3] = '{inst: 1, n: 4, ops: mk(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000),
                    toggle: 1, stall: 0, poke: 0, exp_sum: 32'h41200000, exp_lat: -1,
                    exp_hs: 4, exp_add: 9, exp_rdy: 1};
`ifdef FP_ZERO_BYPASS_EN
        vecs[4] = '{inst: 1, n: 3, ops: mk(32'h40000000, 32'h00000000, 32'h3F800000, 32'h0),
                    toggle: 0, stall: 0, poke: 0, exp_sum: 32'h40400000, exp_lat: 7,
                    exp_hs: 3, exp_add: 3, exp_rdy: 1};
`else
        vecs[4] = '{inst: 1, n: 3, ops: mk(32'h40000000, 32'h00000000, 32'h3F800000, 32'h0),
                    toggle: 0, stall: 0, poke: 0, exp_sum: 32'h40400000, exp_lat: 10,
                    exp_hs: 3, exp_add: 6, exp_rdy: 1};
`endif

        tick();
        tick();
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_in_ready%0d", i), 32'(in_ready[i]), 32'd0);
            chk($sformatf("rst_sum_valid%0d", i), 32'(sum_valid[i]), 32'd0);
            chk($sformatf("rst_sum_data%0d", i), sum_data[i], 32'd0);
            chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
            chk($sformatf("rst_add_a%0d", i), add_a[i], 32'd0);
            chk($sformatf("rst_add_b%0d", i), add_b[i], 32'd0);
        end
        tick();

        for (int v = 0; v < 5; v++) begin
            run(vecs[v].inst, vecs[v].n, vecs[v].ops, vecs[v].toggle, vecs[v].stall,
                vecs[v].poke, res, lat, hs_cnt, add_cyc, stable_ok, rdy_seen, done);
            chk($sformatf("v%0d_finished", v), 32'(done), 32'd1);
            chk($sformatf("v%0d_sum", v), res, vecs[v].exp_sum);
            if (vecs[v].exp_lat >= 0) chk($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
            chk($sformatf("v%0d_handshakes", v), hs_cnt, vecs[v].exp_hs);
            chk($sformatf("v%0d_add_cycles", v), add_cyc, vecs[v].exp_add);
            chk($sformatf("v%0d_in_ready_seen", v), 32'(rdy_seen), 32'(vecs[v].exp_rdy));
            chk($sformatf("v%0d_sum_stable", v), 32'(stable_ok), 32'd1);
            chk($sformatf("v%0d_valid_drop", v), 32'(sum_valid[vecs[v].inst]), 32'd0);
            chk($sformatf("v%0d_busy_drop", v), 32'(busy[vecs[v].inst]), 32'd0);
            tick();
        end

        // Reset in the middle of an ADD on the ADD_LAT=3 instance.
        start[1] = 1'b1; cnt[1] = 8'd3; in_valid[1] = 1'b1; in_data[1] = 32'h40000000;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            start[1] = 1'b0;
            if (busy[1] && !in_ready[1] && !sum_valid[1]) found = 1'b1;
        end
        chk("mid_add_reached", 32'(found), 32'd1);
        in_valid[1] = 1'b0;
        tick();
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        chk("midrst_busy", 32'(busy[1]), 32'd0);
        chk("midrst_in_ready", 32'(in_ready[1]), 32'd0);
        chk("midrst_sum_valid", 32'(sum_valid[1]), 32'd0);
        chk("midrst_sum_data", sum_data[1], 32'd0);
        chk("midrst_add_a", add_a[1], 32'd0);
        chk("midrst_add_b", add_b[1], 32'd0);
        found = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (sum_valid[1] || busy[1]) found = 1'b1;
            tick();
        end
        chk("midrst_no_partial", 32'(found), 32'd0);

        run(1, 1, mk(32'h40800000, 32'h0, 32'h0, 32'h0), 1'b0, 0, 1'b0,
            res, lat, hs_cnt, add_cyc, stable_ok, rdy_seen, done);
        chk("fresh_finished", 32'(done), 32'd1);
        chk("fresh_sum", res, 32'h40800000);
        chk("fresh_latency", lat, 2);
        chk("fresh_handshakes", hs_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
